nmr_bstrm_pls_meas: RTL
=======================

# nmr_bstrm_pls_meas

Single-pulse bitstream measurement block: the receive-side counterpart of the NMR bitstream pulse generator. On START it measures, in CLK cycles, the low time before a pulse, the pulse high width, and the low time after it. It reports the three counts and a status word, using the same START/DONE handshake as the generator. Used for loopback self-test of pulse timing and for capturing externally generated gate pulses.

## Interface
Parameters:
- IDLY_WIDTH, 32, width of measured pre-pulse delay
- PLS_WIDTH, 32, width of measured pulse width
- EDLY_WIDTH, 32, width of measured post-pulse delay
- TMO_WIDTH, 32, width of per-phase timeout
- SYNC_STAGES, 2, IN synchronizer depth (>=2)

Ports:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- START  in  1  level request; held high for the whole measurement
- DONE  out  1  high when idle or finished; low while measuring
- IN  in  1  asynchronous pulse input
- tmo  in  TMO_WIDTH  per-phase cycle limit; 0 disables the timeout; sampled at start
- idly  out  IDLY_WIDTH  measured pre-pulse low cycles
- pls  out  PLS_WIDTH  measured high cycles
- edly  out  EDLY_WIDTH  measured post-pulse low cycles
- STAT  out  4  [0] no rising edge; [1] pulse timeout; [2] edly ended by timeout; [3] counter saturated

## Operation
- IN passes through a SYNC_STAGES flop chain to give in_s. All decisions use in_s. Each CLK edge yields one sample.
- States: S_IDLE, S_WAIT_RISE, S_HIGH, S_LOW, S_DONE (one-hot).
- S_IDLE: DONE=1. On START=1: clear the internal counters, latch tmo, go to S_WAIT_RISE, and drive DONE=0 on the same edge.
- Sample attribution: each sample in a measuring state belongs to the current phase. A sample whose level differs from the phase level counts as the first cycle of the next phase.
- S_WAIT_RISE: if in_s=0, idly_cnt+1; otherwise go to S_HIGH with pls_cnt=1. If IN is already high at the first sample, idly=0.
- S_HIGH: if in_s=1, pls_cnt+1; otherwise go to S_LOW with edly_cnt=1.
- S_LOW: if in_s=0, edly_cnt+1. A high sample ends the phase, is not counted, and gives STAT[2]=0.
- Timeout (tmo!=0): when the active phase counter equals the latched tmo, go to S_DONE.
  - S_WAIT_RISE: STAT[0]=1; pls=0, edly=0.
  - S_HIGH: STAT[1]=1; edly=0.
  - S_LOW: STAT[2]=1. This is the normal end for an isolated pulse.
- tmo=0: each phase runs until an edge occurs. S_LOW then ends only on a rising edge.
- Counters saturate at all-ones and set STAT[3]. They never wrap.
- On entry to S_DONE: idly, pls, edly and STAT are loaded from the counters in one edge, then DONE<=1.
- Outputs hold their values until the next S_DONE entry. They are not cleared at start.
- S_DONE: DONE=1. When START=0, go to S_IDLE. A new measurement requires START to go low and then high again.
- START dropping mid-measurement is ignored; the measurement runs to S_DONE.
- RST at any time: State=S_IDLE, DONE=0, idly=pls=edly=0, STAT=0, synchronizer=0.
  - DONE rises on the first edge after RST release (S_IDLE behaviour).

## Timing
- START to DONE low: 1 edge.
- Input path: a change on IN reaches in_s after SYNC_STAGES edges.
  - idly includes a constant +SYNC_STAGES offset relative to IN.
  - pls and edly are exact, ±1 cycle for asynchronous edges.
- Final sample to S_DONE, outputs and DONE: 1 edge.
- DONE low to high: (idly + pls + edly + 1) cycles on a normal edge-terminated run.
- Minimum pulse resolved: 1 cycle high.
  - A 1-cycle low gap within the pulse ends S_HIGH; no glitch filtering.

## Test plan
- Synchronous IN: SYNC_STAGES low cycles after START, then 10 low, 5 high, 7 low, then high; tmo=0. Expect idly=10+SYNC_STAGES, pls=5, edly=7, STAT=0000; DONE high 1 edge after the rising edge is sampled.
- Isolated pulse: tmo=20, 3 low, 4 high, IN held low. Expect pls=4, edly=20, STAT=0100.
- No pulse: IN held low, tmo=50. Expect idly=50, pls=0, edly=0, STAT=0001, DONE rises 51 cycles after start.
- IN high before START: expect idly=0 (offset-adjusted), pls counted from the first sample.
  - Same setup with IN stuck high and tmo=8: expect pls=8, STAT=0010.
- Saturation: PLS_WIDTH=4, 20-cycle pulse, tmo=0. Expect pls=15 and STAT[3]=1.
- Handshake and reset:
  - START dropped mid-pulse: measurement completes.
  - START held high after DONE: no restart; outputs stable.
  - RST asserted in S_HIGH: all outputs 0 immediately, DONE=1 on the next edge; a new START measures correctly.

Source files
------------

// File: rtl/nmr_bstrm_pls_meas.sv
// Single-pulse bitstream measurement: counts pre-pulse low, pulse high and
// post-pulse low cycles of a synchronized input under a START/DONE handshake.
module nmr_bstrm_pls_meas #(
  parameter int IDLY_WIDTH  = 32,
  parameter int PLS_WIDTH   = 32,
  parameter int EDLY_WIDTH  = 32,
  parameter int TMO_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  DONE,
  input  logic                  IN,
  input  logic [TMO_WIDTH-1:0]  tmo,
  output logic [IDLY_WIDTH-1:0] idly,
  output logic [PLS_WIDTH-1:0]  pls,
  output logic [EDLY_WIDTH-1:0] edly,
  output logic [3:0]            STAT
);

  localparam int CW01 = (IDLY_WIDTH > PLS_WIDTH) ? IDLY_WIDTH : PLS_WIDTH;
  localparam int CW23 = (EDLY_WIDTH > TMO_WIDTH) ? EDLY_WIDTH : TMO_WIDTH;
  localparam int CW   = (CW01 > CW23) ? CW01 : CW23;

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_WAIT_RISE = 5'b00010,
    S_HIGH      = 5'b00100,
    S_LOW       = 5'b01000,
    S_DONE      = 5'b10000
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    in_s;
  logic [IDLY_WIDTH-1:0]   idly_cnt_q, idly_cnt_d;
  logic [PLS_WIDTH-1:0]    pls_cnt_q, pls_cnt_d;
  logic [EDLY_WIDTH-1:0]   edly_cnt_q, edly_cnt_d;
  logic [TMO_WIDTH-1:0]    tmo_q, tmo_d;
  logic                    sat_q, sat_d;
  logic                    done_d;
  logic [IDLY_WIDTH-1:0]   idly_d;
  logic [PLS_WIDTH-1:0]    pls_d;
  logic [EDLY_WIDTH-1:0]   edly_d;
  logic [3:0]              stat_d;
  logic                    finish;
  logic [2:0]              fin_stat;
  logic                    tmo_en, idly_hit, pls_hit, edly_hit;

  assign in_s     = sync_q[SYNC_STAGES-1];
  assign tmo_en   = (tmo_q != '0);
  assign idly_hit = tmo_en && (CW'(idly_cnt_q) == CW'(tmo_q));
  assign pls_hit  = tmo_en && (CW'(pls_cnt_q)  == CW'(tmo_q));
  assign edly_hit = tmo_en && (CW'(edly_cnt_q) == CW'(tmo_q));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      idly_cnt_q <= '0;
      pls_cnt_q  <= '0;
      edly_cnt_q <= '0;
      tmo_q      <= '0;
      sat_q      <= 1'b0;
      DONE       <= 1'b0;
      idly       <= '0;
      pls        <= '0;
      edly       <= '0;
      STAT       <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], IN};
      idly_cnt_q <= idly_cnt_d;
      pls_cnt_q  <= pls_cnt_d;
      edly_cnt_q <= edly_cnt_d;
      tmo_q      <= tmo_d;
      sat_q      <= sat_d;
      DONE       <= done_d;
      idly       <= idly_d;
      pls        <= pls_d;
      edly       <= edly_d;
      STAT       <= stat_d;
    end
  end

  // Timeout is checked before the sample, so a phase ends one edge after its
  // counter reaches tmo; that edge also loads the result registers.
  always_comb begin
    state_d    = state_q;
    idly_cnt_d = idly_cnt_q;
    pls_cnt_d  = pls_cnt_q;
    edly_cnt_d = edly_cnt_q;
    tmo_d      = tmo_q;
    sat_d      = sat_q;
    done_d     = DONE;
    idly_d     = idly;
    pls_d      = pls;
    edly_d     = edly;
    stat_d     = STAT;
    finish     = 1'b0;
    fin_stat   = 3'b000;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b1;
        if (START) begin
          idly_cnt_d = '0;
          pls_cnt_d  = '0;
          edly_cnt_d = '0;
          sat_d      = 1'b0;
          tmo_d      = tmo;
          done_d     = 1'b0;
          state_d    = S_WAIT_RISE;
        end
      end
      S_WAIT_RISE: begin
        if (idly_hit) begin
          finish   = 1'b1;
          fin_stat = 3'b001;
        end else if (!in_s) begin
          if (&idly_cnt_q) sat_d = 1'b1;
          else             idly_cnt_d = idly_cnt_q + IDLY_WIDTH'(1);
        end else begin
          pls_cnt_d = PLS_WIDTH'(1);
          state_d   = S_HIGH;
        end
      end
      S_HIGH: begin
        if (pls_hit) begin
          finish   = 1'b1;
          fin_stat = 3'b010;
        end else if (in_s) begin
          if (&pls_cnt_q) sat_d = 1'b1;
          else            pls_cnt_d = pls_cnt_q + PLS_WIDTH'(1);
        end else begin
          edly_cnt_d = EDLY_WIDTH'(1);
          state_d    = S_LOW;
        end
      end
      S_LOW: begin
        if (edly_hit) begin
          finish   = 1'b1;
          fin_stat = 3'b100;
        end else if (!in_s) begin
          if (&edly_cnt_q) sat_d = 1'b1;
          else             edly_cnt_d = edly_cnt_q + EDLY_WIDTH'(1);
        end else begin
          finish = 1'b1;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        if (!START) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    endcase
    if (finish) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      idly_d  = idly_cnt_q;
      pls_d   = pls_cnt_q;
      edly_d  = edly_cnt_q;
      stat_d  = {sat_q, fin_stat};
    end
  end

endmodule
